// File: rtl/s_acq_pkg.sv
// ---------------------------------------------------------------------------
// s_acq_pkg
// Shared definitions for the acquisition sampler:
//   - acq_state_e : window FSM encoding (IDLE, ARM, ACQ, DRAIN, DONE)
//   - FIFO_DEPTH  : output buffer depth, FIFO_AW its pointer index width
//   - DATA_W_DEF / CNT_W_DEF : default ADC word and sample-count widths
// ---------------------------------------------------------------------------
package s_acq_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int CNT_W_DEF  = 12;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_ACQ   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } acq_state_e;

endpackage

// File: rtl/s_acq_if.sv
// ---------------------------------------------------------------------------
// s_acq_if
// Valid/ready word stream from the sampler to the echo-data packer.
//   dout       : head word (source -> sink)
//   dout_valid : head word valid (source -> sink)
//   dout_ready : sink accepts the word (sink -> source)
// The sampler's DATA_W must match the DATA_W of the connected interface.
// ---------------------------------------------------------------------------
interface s_acq_if
    import s_acq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/s_acq_fifo4.sv
// ---------------------------------------------------------------------------
// s_acq_fifo4
// Synchronous 4-entry FIFO with flush.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   flush      : empty the FIFO (wins over push/pop)
//   push/wdata : write request and word
//   pop        : read request (ignored when empty)
//   rdata      : head word, forced to 0 while empty
//   full/empty : occupancy flags
// A push while full is accepted when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module s_acq_fifo4
    import s_acq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [FIFO_AW:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign do_pop  = pop & ~empty;
    // When full, the slot being written is the head that is popped this cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (do_push && !flush) mem_d[wr_ptr_q[FIFO_AW-1:0]] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is data only; the empty flag masks whatever it holds.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];

endmodule

// File: rtl/s_acq_sampler.sv
// ---------------------------------------------------------------------------
// s_acq_sampler
// Samples adc_data on each rising edge of the divided clock s_clk (treated as
// data in the clk_dds domain) for a window of sample_num samples, buffering
// the words in a 4-entry FIFO behind a valid/ready stream.
//   clk_dds, rst_n      : clock, asynchronous active-low reset
//   entop, s_acq_en     : enables; the window runs while both are high
//   s_clk               : divided acquisition clock (clk_dds/4)
//   adc_data            : ADC word, stable around the s_clk rising edge
//   sample_num          : samples per window, latched at window start
//   out_if (master)     : dout / dout_valid / dout_ready word stream
//   acq_busy            : window in progress (ACQ or DRAIN)
//   acq_done            : one-cycle pulse when a window completes
//   acq_ovf             : sticky, a sample was dropped in this window
// ---------------------------------------------------------------------------
module s_acq_sampler
    import s_acq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_dds,
    input  logic              rst_n,
    input  logic              entop,
    input  logic              s_acq_en,
    input  logic              s_clk,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [CNT_W-1:0]  sample_num,
    s_acq_if.master           out_if,
    output logic              acq_busy,
    output logic              acq_done,
    output logic              acq_ovf
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    acq_state_e        state_q, state_d;
    logic              en_prev_q, en_prev_d;
    logic              s_clk_d_q, s_clk_d_d;
    logic [CNT_W-1:0]  num_r_q, num_r_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic              en;
    logic              en_rise;
    logic              strobe;
    logic [CNT_W-1:0]  cnt_inc;
    logic              abort;
    logic              arm_go;
    logic              fifo_flush;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;
    logic [DATA_W-1:0] fifo_rdata;

    assign en       = entop & s_acq_en;
    assign en_rise  = en & ~en_prev_q;
    assign strobe   = s_clk & ~s_clk_d_q & (state_q == ST_ACQ);
    assign cnt_inc  = cnt_q + CNT_ONE;

    // Losing the enable mid-window abandons it without a completion pulse.
    assign abort    = ~en & ((state_q == ST_ARM) | (state_q == ST_ACQ) |
                             (state_q == ST_DRAIN));
    assign arm_go   = (state_q == ST_ARM) & en;

    assign fifo_flush = arm_go | abort;
    assign fifo_push  = strobe & en;
    assign fifo_pop   = ~fifo_empty & out_if.dout_ready;
    // A full FIFO still takes the word if the head leaves in the same cycle.
    assign drop       = fifo_push & fifo_full & ~fifo_pop;

    s_acq_fifo4 #(.DATA_W(DATA_W)) u_fifo (
        .clk   (clk_dds),
        .rst_n (rst_n),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (adc_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register
    always_ff @(posedge clk_dds or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (en_rise) state_d = ST_ARM;
            ST_ARM: begin
                if (!en)                   state_d = ST_IDLE;
                else if (sample_num == '0) state_d = ST_DONE;
                else                       state_d = ST_ACQ;
            end
            ST_ACQ: begin
                if (!en)                                 state_d = ST_IDLE;
                else if (strobe && (cnt_inc == num_r_q)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!en)             state_d = ST_IDLE;
                else if (fifo_empty) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        acq_busy = (state_q == ST_ACQ) | (state_q == ST_DRAIN);
        acq_done = (state_q == ST_DONE);
    end

    // Window bookkeeping: edge history, latched length, strobe count, overflow.
    // cnt counts dropped strobes too, so the window length never stretches.
    always_comb begin
        en_prev_d = en;
        s_clk_d_d = s_clk;
        num_r_d   = arm_go ? sample_num : num_r_q;
        cnt_d     = cnt_q;
        if (fifo_flush)  cnt_d = '0;
        else if (strobe) cnt_d = cnt_inc;
        ovf_d = ovf_q;
        if (arm_go)    ovf_d = 1'b0;
        else if (drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_dds or negedge rst_n) begin
        if (!rst_n) begin
            en_prev_q <= 1'b0;
            s_clk_d_q <= 1'b0;
            num_r_q   <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            en_prev_q <= en_prev_d;
            s_clk_d_q <= s_clk_d_d;
            num_r_q   <= num_r_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_if.dout       = fifo_rdata;
    assign out_if.dout_valid = ~fifo_empty;
    assign acq_ovf           = ovf_q;

endmodule

// File: tb/tb_s_acq_sampler.sv
// ---------------------------------------------------------------------------
// tb_s_acq_sampler
// Scenario tasks drive the sampler and compare every cycle against a
// window/queue reference model kept in the bench.
// ---------------------------------------------------------------------------
module tb_s_acq_sampler;
    import s_acq_pkg::*;

    localparam int DW = 12;
    localparam int CW = 12;

    logic          clk_dds = 1'b0;
    logic          rst_n;
    logic          entop;
    logic          s_acq_en;
    logic          s_clk;
    logic [DW-1:0] adc_data;
    logic [CW-1:0] sample_num;
    logic          acq_busy;
    logic          acq_done;
    logic          acq_ovf;

    s_acq_if #(.DATA_W(DW)) bus ();

    s_acq_sampler #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_dds    (clk_dds),
        .rst_n      (rst_n),
        .entop      (entop),
        .s_acq_en   (s_acq_en),
        .s_clk      (s_clk),
        .adc_data   (adc_data),
        .sample_num (sample_num),
        .out_if     (bus),
        .acq_busy   (acq_busy),
        .acq_done   (acq_done),
        .acq_ovf    (acq_ovf)
    );

    always #5 clk_dds = ~clk_dds;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a window is described by the cycle it arms in, the
    // strobes it still has to take, and the cycle its done pulse is due.
    logic [DW-1:0] mq[$];
    bit            m_open;
    bit            m_ovf;
    bit            m_sclk_prev;
    bit            m_en_prev;
    int            m_arm_at;
    int            m_done_at;
    int            m_left;

    // Stimulus and observation state
    int            ph;
    bit            adc_rand;
    logic [DW-1:0] adc_base;
    logic [DW-1:0] rx[$];
    int            done_cnt;

    function automatic logic [DW+3:0] exp_vec();
        logic          v;
        logic          b;
        logic          d;
        logic [DW-1:0] h;
        v = (mq.size() != 0);
        h = v ? mq[0] : '0;
        b = m_open && (cyc > m_arm_at) && ((m_done_at < 0) || (cyc < m_done_at));
        d = m_open && (cyc == m_done_at);
        return {v, h, b, d, m_ovf};
    endfunction

    function automatic logic [DW+3:0] act_vec();
        return {bus.dout_valid, bus.dout, acq_busy, acq_done, acq_ovf};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_open      = 1'b0;
        m_ovf       = 1'b0;
        m_sclk_prev = 1'b0;
        m_en_prev   = 1'b0;
        m_arm_at    = -10;
        m_done_at   = -1;
        m_left      = 0;
        ph          = 0;
    endtask

    task automatic model_update(input bit en, input bit sclk, input logic [DW-1:0] adc,
                                input bit rdy, input logic [CW-1:0] snum);
        bit pop;
        bit stb;
        pop = (mq.size() != 0) && rdy;
        stb = sclk && !m_sclk_prev;
        if (m_open && cyc >= m_arm_at && cyc != m_done_at && !en) begin
            mq.delete();
            m_open = 1'b0;
        end else if (m_open && cyc == m_done_at) begin
            if (pop) mq.delete(0);
            m_open = 1'b0;
        end else if (m_open && cyc == m_arm_at) begin
            mq.delete();
            m_ovf     = 1'b0;
            m_left    = int'(snum);
            m_done_at = (snum == '0) ? cyc + 1 : -1;
        end else if (m_open) begin
            if (m_left == 0) begin
                if (m_done_at < 0 && mq.size() == 0) m_done_at = cyc + 1;
                if (pop) mq.delete(0);
            end else begin
                if (pop) mq.delete(0);
                if (stb) begin
                    if (mq.size() < 4) mq.push_back(adc);
                    else               m_ovf = 1'b1;
                    m_left--;
                end
            end
        end else begin
            if (pop) mq.delete(0);
            if (en && !m_en_prev) begin
                m_open    = 1'b1;
                m_arm_at  = cyc + 1;
                m_done_at = -1;
            end
        end
        m_sclk_prev = sclk;
        m_en_prev   = en;
    endtask

    // One clk_dds cycle: derive s_clk/adc_data, note the handshake, advance.
    task automatic step();
        bit en_now;
        en_now = entop & s_acq_en;
        if (!en_now) ph = 0;
        s_clk    = en_now && ((ph % 4) >= 2);
        adc_data = adc_rand ? DW'($urandom) : adc_base + DW'(ph / 4);
        if (bus.dout_valid && bus.dout_ready) rx.push_back(bus.dout);
        if (acq_done) done_cnt++;
        model_update(en_now, s_clk, adc_data, bus.dout_ready, sample_num);
        if (en_now) ph++;
        @(posedge clk_dds);
        @(negedge clk_dds);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; entop = 1'b0; s_acq_en = 1'b0; s_clk = 1'b0;
        adc_data = '0; sample_num = '0; bus.dout_ready = 1'b0;
        adc_rand = 1'b0; adc_base = '0; done_cnt = 0;
        model_reset();
        @(negedge clk_dds);
        @(negedge clk_dds);
        checks++;
        if (act_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", act_vec(), '0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_window_length();
        logic [DW-1:0] w;
        sample_num = 12'd8; bus.dout_ready = 1'b1; adc_rand = 1'b0; adc_base = 12'h100;
        rx.delete(); done_cnt = 0;
        entop = 1'b1; s_acq_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 55) s_acq_en = 1'b0;
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL window_cycle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        checks++;
        if (rx.size() != 8) begin
            errors++;
            $display("FAIL window_word_count got=%0d exp=8", rx.size());
        end
        for (int k = 0; k < 8 && k < rx.size(); k++) begin
            w = 12'h100 + DW'(k);
            checks++;
            if (rx[k] !== w) begin
                errors++;
                $display("FAIL window_word[%0d] got=%h exp=%h", k, rx[k], w);
            end
        end
        checks++;
        if (done_cnt != 1 || acq_ovf !== 1'b0) begin
            errors++;
            $display("FAIL window_done_ovf got=%0d/%b exp=1/0", done_cnt, acq_ovf);
        end
    endtask

    task automatic test_backpressure_overflow();
        logic [DW-1:0] want[$];
        want = '{12'h200, 12'h201, 12'h202, 12'h203, 12'h206, 12'h207, 12'h208, 12'h209};
        sample_num = 12'd10; adc_rand = 1'b0; adc_base = 12'h200;
        rx.delete(); done_cnt = 0;
        s_acq_en = 1'b1;
        for (int i = 0; i < 70; i++) begin
            bus.dout_ready = (i >= 26);
            if (i == 65) s_acq_en = 1'b0;
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ovf_cycle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        checks++;
        if (rx != want) begin
            errors++;
            $display("FAIL ovf_words got=%p exp=%p", rx, want);
        end
        checks++;
        if (acq_ovf !== 1'b1 || done_cnt != 1) begin
            errors++;
            $display("FAIL ovf_flag_done got=%b/%0d exp=1/1", acq_ovf, done_cnt);
        end
    endtask

    task automatic test_push_pop_full();
        sample_num = 12'd5; adc_rand = 1'b0; adc_base = 12'h300;
        rx.delete(); done_cnt = 0;
        s_acq_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.dout_ready = (i >= 18);
            if (i == 36) s_acq_en = 1'b0;
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_pp_cycle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        checks++;
        if (rx.size() != 5 || acq_ovf !== 1'b0 || done_cnt != 1) begin
            errors++;
            $display("FAIL full_pp_result got=%0d/%b/%0d exp=5/0/1", rx.size(), acq_ovf, done_cnt);
        end
    endtask

    task automatic test_zero_length();
        int done_i;
        sample_num = 12'd0; bus.dout_ready = 1'b1; adc_rand = 1'b0; adc_base = '0;
        rx.delete(); done_cnt = 0; done_i = -1;
        s_acq_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (acq_done && done_i < 0) done_i = i + 1;
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL zero_cycle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        s_acq_en = 1'b0;
        step();
        checks++;
        if (done_i != 2 || done_cnt != 1 || rx.size() != 0) begin
            errors++;
            $display("FAIL zero_done got=t+%0d/%0d/%0d exp=t+2/1/0", done_i, done_cnt, rx.size());
        end
    endtask

    task automatic test_abort();
        sample_num = 12'd16; bus.dout_ready = 1'b0; adc_rand = 1'b0; adc_base = 12'h400;
        rx.delete(); done_cnt = 0;
        s_acq_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 12) s_acq_en = 1'b0;
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL abort_cycle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
            if (i == 12) begin
                checks++;
                if (bus.dout_valid !== 1'b0 || acq_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_idle got=%b%b exp=00", bus.dout_valid, acq_busy);
                end
            end
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL abort_no_done got=%0d exp=0", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int nwin;
        nwin = 6;
        adc_rand = 1'b1; rx.delete(); done_cnt = 0;
        for (int w = 0; w < nwin; w++) begin
            sample_num = CW'($urandom_range(1, 12));
            s_acq_en = 1'b1;
            for (int i = 0; i < 200; i++) begin
                bus.dout_ready = ($urandom_range(0, 9) < 6);
                step();
                checks++;
                if (act_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL b2b_cycle win=%0d cyc=%0d got=%h exp=%h", w, cyc, act_vec(), exp_vec());
                end
                if (!m_open) break;
            end
            s_acq_en = 1'b0;
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_gap win=%0d got=%h exp=%h", w, act_vec(), exp_vec());
            end
        end
        checks++;
        if (done_cnt != nwin) begin
            errors++;
            $display("FAIL b2b_done_count got=%0d exp=%0d", done_cnt, nwin);
        end
    endtask

    task automatic test_reset_mid_window();
        sample_num = 12'd12; bus.dout_ready = 1'b0; adc_rand = 1'b0; adc_base = 12'h500;
        rx.delete(); done_cnt = 0;
        s_acq_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rst_pre_cycle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (act_vec() !== '0) begin
            errors++;
            $display("FAIL rst_async_outputs got=%h exp=%h", act_vec(), '0);
        end
        model_reset();
        entop = 1'b0; s_acq_en = 1'b0; s_clk = 1'b0;
        @(negedge clk_dds);
        @(negedge clk_dds);
        cyc += 2;
        rst_n = 1'b1;
        entop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rst_post_idle cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        sample_num = 12'd3; bus.dout_ready = 1'b1; adc_base = 12'h600;
        s_acq_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rst_post_window cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
            end
        end
        checks++;
        if (done_cnt != 1 || rx.size() != 3) begin
            errors++;
            $display("FAIL rst_post_result got=%0d/%0d exp=1/3", done_cnt, rx.size());
        end
        s_acq_en = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_window_length();
        test_backpressure_overflow();
        test_push_pop_full();
        test_zero_length();
        test_abort();
        test_back_to_back();
        test_reset_mid_window();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/s_acq_sampler.md
# s_acq_sampler

Downstream consumer of the divided acquisition clock from the clk_dds divide-by-4 stage. It detects rising edges of that clock in the clk_dds domain, captures one ADC word per edge for a programmed window length, and buffers the words in a 4-entry FIFO behind a valid/ready output port. It sits between the DDS clock divider and the echo-data packer and reports window completion and overflow to the acquisition controller.

## Interface
- DATA_W, 12: ADC word width.
- CNT_W, 12: width of the sample-count register.
- clk_dds  in  1  DDS system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- entop  in  1  top-level acquisition enable.
- s_acq_en  in  1  acquisition window enable. The block runs only while `en = entop & s_acq_en`.
- s_clk  in  1  divided clock (clk_dds/4, registered on clk_dds, low while disabled). Treated as data, not as a clock.
- adc_data  in  DATA_W  ADC output word, stable around the s_clk rising edge.
- sample_num  in  CNT_W  samples per window; latched at window start.
- dout  out  DATA_W  FIFO head word.
- dout_valid  out  1  head word valid.
- dout_ready  in  1  downstream accepts the word.
- acq_busy  out  1  window in progress (ACQ or DRAIN).
- acq_done  out  1  one-cycle pulse at window completion.
- acq_ovf  out  1  sticky: a sample was dropped in this window.

## Operation
- Edge detect: `s_clk_d` is s_clk registered; `strobe = s_clk & ~s_clk_d & (state==ACQ)`.
- FSM states:
  - IDLE → ARM on the rising edge of en.
  - ARM: latch sample_num into `num_r`, clear cnt, clear acq_ovf, flush the FIFO. Go to DONE if sample_num==0, else to ACQ.
  - ACQ: on each strobe, push adc_data if the FIFO is not full; otherwise drop the word and set acq_ovf. cnt increments on every strobe, dropped or not, so the window length stays fixed. When cnt reaches num_r, go to DRAIN.
  - DRAIN → DONE when the FIFO is empty.
  - DONE: acq_done=1 for one cycle, then IDLE.
- en low in any state other than IDLE or DONE aborts the window: next state is IDLE, FIFO flushed, cnt cleared, no acq_done pulse, acq_ovf kept.
- FIFO:
  - 4 entries, pointers 2 bits plus 1 wrap bit.
  - Pop when dout_valid & dout_ready.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full: the pop frees a slot and the push is accepted, with no overflow.
- cnt: CNT_W bits, compared for equality with num_r. It never wraps, because the window ends at num_r.
- acq_busy = (state==ACQ) | (state==DRAIN).

## Timing
- Reset values: dout=0, dout_valid=0, acq_busy=0, acq_done=0, acq_ovf=0, s_clk_d=0, state=IDLE, FIFO empty.
- Rising edge of en at cycle t: ARM at t+1, ACQ at t+2.
- Strobe at cycle t: the word is written at the end of t, and dout_valid is high at t+1. Latency is 1 cycle.
- Strobe period is 4 clk_dds cycles, so at most one push every 4 cycles.
- dout is held stable while dout_valid=1 and dout_ready=0.
- Last strobe at cycle t (cnt reaches num_r): DRAIN at t+1. DONE follows the cycle after the FIFO goes empty, and acq_done pulses in the DONE cycle.

## Structure
- Shared package `s_acq_pkg` holds:
  - the FSM state encoding (IDLE, ARM, ACQ, DRAIN, DONE);
  - the FIFO depth constant (4);
  - defaults for DATA_W and CNT_W.
- One sub-module, `s_acq_fifo4`: synchronous 4-entry FIFO with flush, push, pop, full and empty.

## Test plan
- Window length: sample_num=8, dout_ready tied high, adc_data incrementing from 0x100 → exactly 8 words (sampled at the s_clk rising edges), acq_done once, acq_ovf=0.
- Back-pressure overflow: sample_num=10, dout_ready=0 for the first 24 cycles of ACQ → 4 words buffered, following strobes dropped, acq_ovf=1. Window still ends after 10 strobes; after ready is released, the 4 buffered words drain and acq_done pulses.
- Zero-length window: sample_num=0, en rising → ARM, then DONE, acq_done at t+2, no dout_valid.
- Abort: en dropped after 3 strobes of a 16-sample window → IDLE next cycle, dout_valid=0, no acq_done.
- Push and pop together at full: FIFO full and dout_ready=1 in a strobe cycle → word accepted, acq_ovf stays 0.
- Reset mid-window: rst_n asserted in ACQ → all outputs 0 immediately (asynchronous), IDLE after release.
